// File: rtl/seq_stream_src_if.sv
// Valid/ready message channel for seq_stream_src.
// SEQ_STREAM_SRC_PARITY_EN adds the par (even parity) signal.
interface seq_stream_src_if #(
    parameter int p_nbits = 8
);
    logic               val;
    logic               rdy;
    logic [p_nbits-1:0] msg;
`ifdef SEQ_STREAM_SRC_PARITY_EN
    logic               par;
`endif

    modport master (
        output val,
        output msg,
`ifdef SEQ_STREAM_SRC_PARITY_EN
        output par,
`endif
        input  rdy
    );

    modport slave (
        input  val,
        input  msg,
`ifdef SEQ_STREAM_SRC_PARITY_EN
        input  par,
`endif
        output rdy
    );
endinterface

// File: rtl/seq_stream_src.sv
// Arithmetic-sequence message source over a val/rdy channel.
// Optional SEQ_STREAM_SRC_PARITY_EN adds out.par = ^out.msg.
module seq_stream_src #(
    parameter int p_nbits    = 8,
    parameter int p_num_msgs = 4,
    parameter int p_start    = 0,
    parameter int p_step     = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              en,
    input  logic                              clear,
    seq_stream_src_if.master                  out,
    output logic                              done,
    output logic [$clog2(p_num_msgs+1)-1:0]   count
);
    localparam int CW = $clog2(p_num_msgs + 1);
    localparam logic [p_nbits-1:0] START = p_nbits'(p_start);
    localparam logic [p_nbits-1:0] STEP  = p_nbits'(p_step);
    localparam logic [CW-1:0]      LAST  = CW'(p_num_msgs - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [p_nbits-1:0] msg_q, msg_d;
    logic [CW-1:0]      count_q, count_d;
    logic               done_q, done_d;
    logic               val;
    logic               fire;

    // clear kills valid in the same cycle so no transfer can slip through
    assign val  = (state_q == SEND) && !clear;
    assign fire = val && out.rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            msg_q   <= START;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        count_d = count_q;
        done_d  = done_q;
        if (clear) begin
            state_d = IDLE;
            msg_d   = START;
            count_d = '0;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (en) state_d = SEND;
                end
                SEND: begin
                    // en only matters once the pending message has gone
                    if (fire) begin
                        count_d = count_q + 1'b1;
                        msg_d   = msg_q + STEP;
                        if (count_q == LAST) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else if (!en) begin
                            state_d = IDLE;
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign out.val = val;
    assign out.msg = msg_q;
    assign done    = done_q;
    assign count   = count_q;

`ifdef SEQ_STREAM_SRC_PARITY_EN
    assign out.par = reset && (^msg_q);
`endif
endmodule

// File: tb/tb_seq_stream_src.sv
// Directed bench for seq_stream_src: default and wrapping instances.
// Inputs change 1 time unit after posedge, outputs sampled 2 units after.
module tb_seq_stream_src;
    logic       clk;
    logic       reset, en, clear;
    logic       reset_w, en_w, clear_w;
    logic       done, done_w;
    logic [2:0] count, count_w;
    int         n_run;
    int         n_fail;

    seq_stream_src_if #(.p_nbits(8)) sif ();
    seq_stream_src_if #(.p_nbits(8)) wif ();

    seq_stream_src dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clear (clear),
        .out   (sif.master),
        .done  (done),
        .count (count)
    );

    seq_stream_src #(
        .p_start (8'hFE)
    ) dut_w (
        .clk   (clk),
        .reset (reset_w),
        .en    (en_w),
        .clear (clear_w),
        .out   (wif.master),
        .done  (done_w),
        .count (count_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [7:0] m, input logic [2:0] c,
                           input logic d);
        check({tag, ".val"},   32'(sif.val), 32'(v));
        check({tag, ".msg"},   32'(sif.msg), 32'(m));
        check({tag, ".count"}, 32'(count),   32'(c));
        check({tag, ".done"},  32'(done),    32'(d));
    endtask

    task automatic chk_w(input string tag, input logic v,
                         input logic [7:0] m, input logic d);
        check({tag, ".val"},  32'(wif.val), 32'(v));
        check({tag, ".msg"},  32'(wif.msg), 32'(m));
        check({tag, ".done"}, 32'(done_w),  32'(d));
    endtask

    initial begin
        n_run   = 0;
        n_fail  = 0;
        reset   = 1'b0;
        en      = 1'b0;
        clear   = 1'b0;
        sif.rdy = 1'b1;
        reset_w = 1'b0;
        en_w    = 1'b1;
        clear_w = 1'b0;
        wif.rdy = 1'b1;

        tick();
        chk_out("reset", 1'b0, 8'h00, 3'd0, 1'b0);
`ifdef SEQ_STREAM_SRC_PARITY_EN
        check("reset.par", 32'(sif.par), 32'd0);
`endif
        #1 reset = 1'b1;

        // enable gating
        for (int i = 0; i < 5; i++) begin
            tick();
            check("gate.val",   32'(sif.val), 32'd0);
            check("gate.count", 32'(count),   32'd0);
        end
        #1 en = 1'b1;
        tick();
        chk_out("start", 1'b1, 8'h00, 3'd0, 1'b0);
        tick();
        chk_out("msg1", 1'b1, 8'h01, 3'd1, 1'b0);
`ifdef SEQ_STREAM_SRC_PARITY_EN
        check("msg1.par", 32'(sif.par), 32'd1);
`endif

        // backpressure while holding 01
        sif.rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("stall", 1'b1, 8'h01, 3'd1, 1'b0);
        end
        sif.rdy = 1'b1;
        tick();
        chk_out("msg2", 1'b1, 8'h02, 3'd2, 1'b0);
        tick();
        chk_out("msg3", 1'b1, 8'h03, 3'd3, 1'b0);
        tick();
        chk_out("done", 1'b0, 8'h04, 3'd4, 1'b1);
        tick();
        chk_out("done_hold", 1'b0, 8'h04, 3'd4, 1'b1);

        // clear from DONE, then clear mid-run after 01
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1 chk_out("clr_idle", 1'b0, 8'h00, 3'd0, 1'b0);
        tick();
        chk_out("rs_start", 1'b1, 8'h00, 3'd0, 1'b0);
        tick();
        chk_out("rs_msg1", 1'b1, 8'h01, 3'd1, 1'b0);
        clear = 1'b1;
        #1 check("clr.val_same", 32'(sif.val), 32'd0);
        tick();
        clear = 1'b0;
        #1 chk_out("clr_mid", 1'b0, 8'h00, 3'd0, 1'b0);
        tick();
        chk_out("rr_start", 1'b1, 8'h00, 3'd0, 1'b0);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk_out("rr_msg", 1'b1, 8'(k), 3'(k), 1'b0);
        end
        tick();
        chk_out("rr_done", 1'b0, 8'h04, 3'd4, 1'b1);

        // async reset while stalled on 02
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        chk_out("ar_start", 1'b1, 8'h00, 3'd0, 1'b0);
        tick();
        tick();
        chk_out("ar_msg2", 1'b1, 8'h02, 3'd2, 1'b0);
        sif.rdy = 1'b0;
        tick();
        chk_out("ar_stall", 1'b1, 8'h02, 3'd2, 1'b0);
        #1 reset = 1'b0;
        #1 chk_out("ar_async", 1'b0, 8'h00, 3'd0, 1'b0);
        #1 reset = 1'b1;
        sif.rdy = 1'b1;
        tick();
        chk_out("ar_restart", 1'b1, 8'h00, 3'd0, 1'b0);

        // wrapping instance: FE, FF, 00, 01, done
        #1 reset_w = 1'b1;
        tick();
        chk_w("w0", 1'b1, 8'hFE, 1'b0);
        tick();
        chk_w("w1", 1'b1, 8'hFF, 1'b0);
        tick();
        chk_w("w2", 1'b1, 8'h00, 1'b0);
        tick();
        chk_w("w3", 1'b1, 8'h01, 1'b0);
        tick();
        chk_w("wdone", 1'b0, 8'h02, 1'b1);
        check("wdone.count", 32'(count_w), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
